// File: rtl/softmax_pkg.sv
// Shared softmax datapath constants and types.
// Log2 unit defaults: Q16.16 in, Q5.16 out.
package softmax_pkg;

    localparam int LOG2_FRAC_IN  = 16;
    localparam int LOG2_FRAC_OUT = 16;
    localparam int LOG2_OUT_W    = 6 + LOG2_FRAC_OUT;

    typedef logic signed [LOG2_OUT_W-1:0] log2_out_t;

    localparam log2_out_t LOG2_NEG_SAT = {1'b1, {(LOG2_OUT_W-1){1'b0}}};

endpackage

// File: rtl/lod.sv
// Leading-one detector: index of the most significant set bit.
// A zero operand reports position 0.
module lod #(
    parameter int W  = 32,
    parameter int PW = $clog2(W)
) (
    input  logic [W-1:0]  din,
    output logic [PW-1:0] pos
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (din[i]) pos = PW'(i);
        end
    end

endmodule

// File: rtl/softmax_log2.sv
// Two-stage Mitchell log2 for the softmax datapath, valid/ready both sides.
// Define SOFTMAX_LOG2_CORR_EN to add the Mitchell mantissa correction.
module softmax_log2
    import softmax_pkg::*;
#(
    parameter int FRAC_IN  = LOG2_FRAC_IN,
    parameter int FRAC_OUT = LOG2_FRAC_OUT,
    parameter int OUT_W    = 6 + FRAC_OUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_zero,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

    logic                s1_valid;
    logic [4:0]          s1_pos;
    logic [FRAC_OUT-1:0] s1_mant;
    logic                s1_zero;

    logic [4:0]          pos;
    logic [FRAC_OUT-1:0] mant;
    logic                s2_adv;
    logic [5:0]          ip;
    logic [FRAC_OUT-1:0] frac;

    lod #(.W(32)) u_lod (
        .din (in_data),
        .pos (pos)
    );

    // Normalise so the leading one lands on bit 31, keep the bits below it.
    assign mant = FRAC_OUT'((in_data << (5'd31 - pos)) >> (31 - FRAC_OUT));

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pos   <= '0;
            s1_mant  <= '0;
            s1_zero  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_pos  <= pos;
                s1_mant <= mant;
                s1_zero <= (in_data == 32'd0);
            end
        end
    end

`ifdef SOFTMAX_LOG2_CORR_EN
    // m + m(1-m)*(1/4 + 1/16 + 1/32); peaks well below 1 so no integer carry.
    function automatic logic [FRAC_OUT-1:0] mitchell_corr(
        input logic [FRAC_OUT-1:0] m
    );
        logic [FRAC_OUT:0]     cm;
        logic [2*FRAC_OUT+1:0] prod;
        logic [FRAC_OUT-1:0]   t;
        cm   = {1'b1, {FRAC_OUT{1'b0}}} - {1'b0, m};
        prod = {{(FRAC_OUT+2){1'b0}}, m} * {{(FRAC_OUT+1){1'b0}}, cm};
        t    = FRAC_OUT'(prod >> FRAC_OUT);
        return m + (t >> 2) + (t >> 4) + (t >> 5);
    endfunction

    assign frac = mitchell_corr(s1_mant);
`else
    assign frac = s1_mant;
`endif

    assign ip = {1'b0, s1_pos} - 6'(FRAC_IN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_zero <= s1_zero;
                out_data <= s1_zero ? NEG_SAT : {ip, frac};
            end
        end
    end

endmodule

// File: tb/tb_softmax_log2.sv
// Self-checking bench for softmax_log2 with an in-order scoreboard.
// Honours SOFTMAX_LOG2_CORR_EN in its reference model.
module tb_softmax_log2;
    import softmax_pkg::*;

    localparam int FI = LOG2_FRAC_IN;
    localparam int FO = LOG2_FRAC_OUT;
    localparam int OW = 6 + FO;
    localparam int NRAND = 10000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_zero;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int popped = 0;
    logic [OW:0] sbq[$];
    logic [OW:0] sb_exp;

    softmax_log2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: log2 = p + (x/2^p - 1), fraction taken by exact scaling.
    function automatic logic [OW:0] model(input logic [31:0] x);
        int p;
        longint unsigned s, f, t;
        logic [5:0] ip;
        if (x == 32'd0) return {1'b1, LOG2_NEG_SAT};
        p = 0;
        for (int i = 0; i < 32; i++) if (x[i]) p = i;
        s = ({32'd0, x} << FO) >> p;
        f = s - (64'd1 << FO);
`ifdef SOFTMAX_LOG2_CORR_EN
        t = (f * ((64'd1 << FO) - f)) >> FO;
        f = f + (t >> 2) + (t >> 4) + (t >> 5);
`else
        t = 0;
`endif
        ip = 6'(p - FI);
        return {1'b0, ip, f[FO-1:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'd1;
            default: return $urandom >> $urandom_range(31);
        endcase
    endfunction

    // Scoreboard: push on accept, pop on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data=%h zero=%b, none expected",
                             out_data, out_zero);
                end else begin
                    sb_exp = sbq.pop_front();
                    popped++;
                    if ({out_zero, out_data} !== sb_exp) begin
                        errors++;
                        $display("FAIL sb_order: got zero=%b data=%h, expected zero=%b data=%h",
                                 out_zero, out_data, sb_exp[OW], sb_exp[OW-1:0]);
                    end
                end
            end
            if (in_valid && in_ready) sbq.push_back(model(in_data));
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_zero, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b zero=%b data=%h, expected all 0",
                     out_valid, out_zero, out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [31:0]   vin[6];
        logic [OW-1:0] vout[6];
        logic          vz[6];
        vin  = '{32'h0001_0000, 32'h0002_0000, 32'h0001_8000,
                 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
`ifdef SOFTMAX_LOG2_CORR_EN
        vout = '{22'h000000, 22'h010000, 22'h009600,
                 22'h300000, 22'h0FFFFF, 22'h200000};
`else
        vout = '{22'h000000, 22'h010000, 22'h008000,
                 22'h300000, 22'h0FFFFF, 22'h200000};
`endif
        vz   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = vin[k];
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec_in_ready[%0d]: got %b, expected 1", k, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec_early[%0d]: out_valid=%b one edge after accept, expected 0",
                         k, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== vout[k] || out_zero !== vz[k]) begin
                errors++;
                $display("FAIL vec[%0d] in=%h: got v=%b d=%h z=%b, expected v=1 d=%h z=%b",
                         k, vin[k], out_valid, out_data, out_zero, vout[k], vz[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0]   ops[5];
        logic [OW-1:0] held;
        logic          acc;
        int            idx;
        ops = '{32'h0000_0100, 32'h0004_0000, 32'h0000_0000,
                32'h1234_5678, 32'h0000_C000};
        idx = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = ops[0];
        repeat (6) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 5) in_data = ops[idx];
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill: accepts=%0d in_ready=%b out_valid=%b, expected 2/0/1",
                     idx, in_ready, out_valid);
        end
        held = out_data;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== held || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got d=%h v=%b, expected d=%h v=1",
                         out_data, out_valid, held);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_gap: out_valid=%b at drain slot %0d, expected 1",
                         out_valid, k);
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 5) in_data = ops[idx];
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (idx != 5 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: accepts=%0d out_valid=%b, expected 5/0", idx, out_valid);
        end
    endtask

    task automatic test_reset_in_flight();
        int stale;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0003;
        @(posedge clk); #1;
        in_data  = 32'h0008_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_flight: got v=%b d=%h, expected v=0 d=0", out_valid, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rst_stale: %0d cycles with out_valid after release, expected 0",
                     stale);
        end
        in_valid = 1'b1;
        in_data  = 32'h0002_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 22'h010000 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_next: got v=%b d=%h z=%b, expected v=1 d=010000 z=0",
                     out_valid, out_data, out_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int   sent, cyc, base;
        logic acc;
        sent = 0;
        cyc  = 0;
        base = popped;
        in_valid = 1'b0;
        while (sent < NRAND && cyc < 60000) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                in_data  = rand_op();
            end
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        checks++;
        if (sent != NRAND) begin
            errors++;
            $display("FAIL rand_timeout: sent %0d of %0d operands", sent, NRAND);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0 || popped - base != sent) begin
            errors++;
            $display("FAIL rand_count: got %0d results, %0d pending, expected %0d and 0",
                     popped - base, sbq.size(), sent);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_in_flight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/softmax_log2.md
Name: softmax_log2

Overview:
- Pipelined fixed-point log2 unit (Mitchell approximation) for the softmax datapath.
- Consumes unsigned fixed-point magnitudes and returns signed fixed-point log2 values.
- Sits directly downstream of the lod leading-one detector; instantiates lod to find the exponent, then normalises the mantissa.
- Valid/ready on both sides, so it can sit between the exp-sum accumulator and the log-domain subtract stage.

Parameters:
- FRAC_IN, 16: fractional bits of the input; input is unsigned Q(32-FRAC_IN).FRAC_IN, 0 < FRAC_IN < 32.
- FRAC_OUT, 16: fractional bits of the output, 1..31.
- OUT_W, 6+FRAC_OUT: output width, signed two's complement. Integer part range is -31..31.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_data, input, 32: unsigned fixed-point operand.
- in_valid, input, 1: operand valid.
- in_ready, output, 1: stage can accept an operand.
- out_data, output, OUT_W: log2(in_data), signed Q5.FRAC_OUT.
- out_zero, output, 1: operand was zero; out_data is saturated.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.

Behaviour:
- Reset (async assert, sync release on clk): all stage valids = 0, out_valid = 0, out_data = 0, out_zero = 0. Reset mid-operation discards all in-flight operands; nothing is emitted after release until new input arrives.
- Handshake:
  - Transfer occurs when valid && ready are high on a rising edge.
  - in_ready = !s1_valid || s2_adv, where s2_adv = !out_valid || out_ready. This is a combinational ready chain with no skid buffer.
  - in_valid and in_ready must not depend on each other combinationally upstream.
- Stage 1 (accept edge):
  - pos = lod(in_data).
  - Register pos, norm = in_data << (31 - pos) (32 bits, bit 31 set when nonzero), and zero = (in_data == 0).
- Stage 2 (next edge, if s2_adv):
  - ip = pos - FRAC_IN, signed 6-bit.
  - m = norm[30 -: FRAC_OUT]; zero-pad on the right if FRAC_OUT > 31.
  - out_data = {ip, m}.
  - If zero: out_data = most negative OUT_W value (1 followed by zeros), out_zero = 1. Otherwise out_zero = 0.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 result/cycle.
- Capacity: 2 operands in flight.
- Stall:
  - While out_valid && !out_ready, out_data and out_zero hold stable.
  - Stage 1 may still fill; in_ready drops once both stages are occupied.
- Simultaneous accept and output with a full pipeline: both transfers happen in the same cycle, with no bubble.
- Ordering: strictly in-order, no reordering or drop.
- Arithmetic: truncation only, no rounding. Stage 2 fraction is always < 1, so the integer field never overflows.

Optional Feature:
- Macro: SOFTMAX_LOG2_CORR_EN.
- Defined: stage 2 adds the Mitchell correction c = t>>2 + t>>4 + t>>5, where t = (m*(2^FRAC_OUT - m)) >> FRAC_OUT. The product is computed at full 2*FRAC_OUT width, each shift truncates, and the result is m + c. The sum stays < 2^FRAC_OUT, so there is no carry into the integer field. Latency is unchanged.
- Undefined: plain Mitchell, m passed through.
- Zero path is unaffected either way.

Decomposition:
- Shared package softmax_pkg holds:
  - LOG2_FRAC_IN and LOG2_FRAC_OUT constants.
  - log2_out_t typedef (signed [OUT_W-1:0]).
  - LOG2_NEG_SAT constant (most negative value).
- One natural sub-module: the existing lod instance in stage 1.
- The correction term is an in-module function, not a separate module.

Test Plan (defaults, out_ready = 1 unless stated):
- in 0x00010000 (1.0) -> out_data 0x000000, out_zero 0, valid 2 cycles after accept. 0x00020000 -> 0x010000.
- in 0x00018000 (1.5) -> without macro 0x008000; with SOFTMAX_LOG2_CORR_EN 0x009600.
- in 0x00000001 -> 0x300000 (-16.0). in 0xFFFFFFFF -> 0x0FFFFF. in 0x00000000 -> 0x200000, out_zero 1.
- Backpressure: stream 5 operands with out_ready held low → in_ready falls after 2 accepts and out_data stays stable. Then raise out_ready → all 5 results emerge in order at 1/cycle with no gaps.
- Assert rst_n low with 2 operands in flight → out_valid drops immediately. After release, no stale results appear; the next operand yields a correct result at latency 2.
- Random 10k operands with random valid/ready vs. a reference model: exact match, in order, no loss or duplication.
